// File: rtl/muldiv_iter_unit_if.sv
// Request/response bundle between the EX stage and the iterative mul/div unit.
// EX owns the master side; the unit itself is the slave.
interface muldiv_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   hilo_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_by_zero_o;
    logic                 stall_req_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        input  result_o, ready_o, busy_o, div_by_zero_o, stall_req_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i, hilo_i,
        output result_o, ready_o, busy_o, div_by_zero_o, stall_req_o
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative multiply / divide / multiply-accumulate unit for the EX stage.
// Operates on operand magnitudes; signs are restored in a single FIX cycle.
module muldiv_iter_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    muldiv_iter_unit_if.slave bus
);
    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 sa_q, sb_q;
    logic [2*WIDTH-1:0]   hilo_q, p_q, p_nxt, res_q, fix_res, prod;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH:0]       tmp, diff, sum;
    logic                 ready_q, dbz_q;

    logic                 is_div, in_div, in_sa, in_sb;
    logic [WIDTH-1:0]     in_mag_a, in_mag_b;

    assign is_div   = (op_q[2:1] == 2'b01);
    assign in_div   = (bus.op_i[2:1] == 2'b01);
    assign in_sa    = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    assign in_sb    = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    assign in_mag_a = in_sa ? -bus.opdata1_i : bus.opdata1_i;
    assign in_mag_b = in_sb ? -bus.opdata2_i : bus.opdata2_i;

    // p_q is {upper, lower}: product accumulator for mul, {remainder, quotient} for div
    always_comb begin
        p_nxt = p_q;
        tmp   = '0;
        diff  = '0;
        sum   = '0;
        for (int s = 0; s < STEPS; s++) begin
            if (is_div) begin
                tmp  = {p_nxt[2*WIDTH-1:WIDTH], p_nxt[WIDTH-1]};
                diff = tmp - {1'b0, b_q};
                if (!diff[WIDTH]) p_nxt = {diff[WIDTH-1:0], p_nxt[WIDTH-2:0], 1'b1};
                else              p_nxt = {tmp[WIDTH-1:0],  p_nxt[WIDTH-2:0], 1'b0};
            end else begin
                sum   = {1'b0, p_nxt[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{p_nxt[0]}}};
                p_nxt = {sum, p_nxt[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod    = (sa_q ^ sb_q) ? -p_q : p_q;
        quo     = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem     = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        fix_res = prod;
        if (is_div)       fix_res = {rem, quo};
        else if (op_q[2]) fix_res = op_q[1] ? hilo_q - prod : hilo_q + prod;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hilo_q  <= '0;
            p_q     <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (bus.annul_i) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    op_q   <= bus.op_i;
                    a_q    <= in_mag_a;
                    b_q    <= in_mag_b;
                    sa_q   <= in_sa;
                    sb_q   <= in_sb;
                    hilo_q <= bus.hilo_i;
                    p_q    <= {{WIDTH{1'b0}}, in_div ? in_mag_a : in_mag_b};
                    cnt    <= '0;
                    if (in_div && bus.opdata2_i == '0) begin
                        state   <= DONE;
                        res_q   <= '0;
                        ready_q <= 1'b1;
                        dbz_q   <= 1'b1;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (!bus.start_i) begin
                    state <= IDLE;
                end else begin
                    p_q <= p_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= FIX;
                end
                FIX: if (!bus.start_i) begin
                    state <= IDLE;
                end else begin
                    res_q   <= fix_res;
                    ready_q <= 1'b1;
                    state   <= DONE;
                end
                DONE: if (!bus.start_i) begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    dbz_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_o      = res_q;
    assign bus.ready_o       = ready_q;
    assign bus.busy_o        = (state != IDLE);
    assign bus.div_by_zero_o = dbz_q;
    assign bus.stall_req_o   = bus.start_i & ~ready_q;
endmodule
